// File: rtl/uart_rx_packet_assembler_if.sv
// ============================================================================
// Module      : uart_rx_packet_assembler_if
// Description : Byte-stream input, RAM write port and packet status bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_packet_assembler_if #(
    parameter int ADDR_W = 4
);
    logic              rx_done;
    logic [7:0]        rx_dout;
    logic [ADDR_W-1:0] mem_write_addr;
    logic [7:0]        mem_write_data;
    logic              mem_write_enable;
    logic              packet_valid;
    logic              packet_error;
    logic [1:0]        error_code;
    logic [7:0]        packet_len;
    logic              busy;

    modport master (
        output rx_done, rx_dout,
        input  mem_write_addr, mem_write_data, mem_write_enable,
        input  packet_valid, packet_error, error_code, packet_len, busy
    );

    modport slave (
        input  rx_done, rx_dout,
        output mem_write_addr, mem_write_data, mem_write_enable,
        output packet_valid, packet_error, error_code, packet_len, busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_packet_assembler.sv
// ============================================================================
// Module      : uart_rx_packet_assembler
// Description : Parses SOF/LEN/payload/XOR-checksum frames from the UART RX
//               byte stream, writes payload to RAM and reports status.
//               Optional inter-byte timeout: define UART_RX_PKT_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_packet_assembler #(
    parameter int         ADDR_W       = 4,
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SOF_BYTE     = 8'hA5,
    parameter int         TIMEOUT_CLKS = 1024
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    uart_rx_packet_assembler_if.slave  bus
);

    localparam int CNT_W = ADDR_W + 1;

    localparam logic [1:0] C_ERR_LEN = 2'b01;
    localparam logic [1:0] C_ERR_CHK = 2'b10;
    localparam logic [1:0] C_ERR_TMO = 2'b11;

    if (MAX_LEN < 1 || MAX_LEN > (1 << ADDR_W) || MAX_LEN > 255 || TIMEOUT_CLKS < 1) begin : g_bad_params
        $error("uart_rx_packet_assembler: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GET_LEN     = 2'd1,
        GET_PAYLOAD = 2'd2,
        GET_CHK     = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next, cnt_inc;
    logic [7:0]        chk_acc, chk_next;
    logic [7:0]        len_q, len_next;
    logic              wr_en, wr_en_next;
    logic [ADDR_W-1:0] wr_addr, wr_addr_next;
    logic [7:0]        wr_data, wr_data_next;
    logic              pkt_valid, pkt_valid_next;
    logic              pkt_error, pkt_error_next;
    logic [1:0]        err_code, err_code_next;
    logic [7:0]        pkt_len, pkt_len_next;

    logic              rx_done;
    logic [7:0]        rx_dout;
    logic              len_bad;
    logic              last_byte;
    logic              tmo_hit;

    assign rx_done   = bus.rx_done;
    assign rx_dout   = bus.rx_dout;
    assign cnt_inc   = cnt + CNT_W'(1);
    assign len_bad   = (rx_dout == 8'd0) || (32'(rx_dout) > 32'(MAX_LEN));
    assign last_byte = (32'(cnt_inc) == 32'(len_q));

`ifdef UART_RX_PKT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Fires on the TIMEOUT_CLKS-th silent busy cycle; the pulse registers next edge.
    assign tmo_hit = (state != IDLE) && !rx_done && (tmo_cnt == TMO_W'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (rx_done || (state == IDLE) || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            chk_acc   <= '0;
            len_q     <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            pkt_valid <= 1'b0;
            pkt_error <= 1'b0;
            err_code  <= '0;
            pkt_len   <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            chk_acc   <= chk_next;
            len_q     <= len_next;
            wr_en     <= wr_en_next;
            wr_addr   <= wr_addr_next;
            wr_data   <= wr_data_next;
            pkt_valid <= pkt_valid_next;
            pkt_error <= pkt_error_next;
            err_code  <= err_code_next;
            pkt_len   <= pkt_len_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        chk_next       = chk_acc;
        len_next       = len_q;
        wr_en_next     = 1'b0;
        wr_addr_next   = wr_addr;
        wr_data_next   = wr_data;
        pkt_valid_next = 1'b0;
        pkt_error_next = 1'b0;
        err_code_next  = err_code;
        pkt_len_next   = pkt_len;

        case (state)
            IDLE: begin
                if (rx_done && (rx_dout == SOF_BYTE)) begin
                    state_next = GET_LEN;
                end
            end
            GET_LEN: begin
                if (rx_done) begin
                    if (len_bad) begin
                        pkt_error_next = 1'b1;
                        err_code_next  = C_ERR_LEN;
                        state_next     = IDLE;
                    end else begin
                        len_next   = rx_dout;
                        chk_next   = rx_dout;
                        cnt_next   = '0;
                        state_next = GET_PAYLOAD;
                    end
                end
            end
            GET_PAYLOAD: begin
                if (rx_done) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = cnt[ADDR_W-1:0];
                    wr_data_next = rx_dout;
                    chk_next     = chk_acc ^ rx_dout;
                    cnt_next     = cnt_inc;
                    if (last_byte) begin
                        state_next = GET_CHK;
                    end
                end
            end
            GET_CHK: begin
                if (rx_done) begin
                    if (rx_dout == chk_acc) begin
                        pkt_valid_next = 1'b1;
                        pkt_len_next   = len_q;
                    end else begin
                        pkt_error_next = 1'b1;
                        err_code_next  = C_ERR_CHK;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Never coincides with rx_done, so it cannot clash with a decoded byte.
        if (tmo_hit) begin
            pkt_error_next = 1'b1;
            err_code_next  = C_ERR_TMO;
            state_next     = IDLE;
        end
    end

    assign bus.mem_write_addr   = wr_addr;
    assign bus.mem_write_data   = wr_data;
    assign bus.mem_write_enable = wr_en;
    assign bus.packet_valid     = pkt_valid;
    assign bus.packet_error     = pkt_error;
    assign bus.error_code       = err_code;
    assign bus.packet_len       = pkt_len;
    assign bus.busy             = (state != IDLE);

endmodule

`default_nettype wire
